g_htruncated_seq: RTL and testbench

//  Sequential high-part truncator: clears the low In2 bits of In1 and keeps the upper bits.
//  Out = (In1 >> n) << n, where n is the shift count derived from In2.

---
 rtl/g_htruncated_seq.sv | 133 +++++++++++++
 tb/tb_g_htruncated_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/g_htruncated_seq.sv
// ---------------------------------------------------------------------------
// g_htruncated_seq
//
// Sequential high-part truncator. Clears the low n bits of In1 and keeps the
// upper bits: Out = (In1 >> n) << n. The shift is done one bit per clock, first
// a right-shift phase and then a left-shift phase. A valid/ready handshake on
// both sides lets the multi-cycle ALU sequencer drive it. Any In2 >= WIDTH
// gives a result of 0.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   In1        in   WIDTH  operand to truncate
//   In2        in   32     truncation count (unsigned)
//   In_valid   in   1      In1/In2 valid
//   In_ready   out  1      operand can be accepted (IDLE only)
//   Out        out  WIDTH  result, held until the next result is produced
//   Out_valid  out  1      result available
//   Out_ready  in   1      consumer accepts the result
//   Busy       out  1      high in any state other than IDLE
// ---------------------------------------------------------------------------
module g_htruncated_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] In1,
  input  logic [31:0]      In2,
  input  logic             In_valid,
  output logic             In_ready,
  output logic [WIDTH-1:0] Out,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic             Busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SHR  = 2'd1;
  localparam logic [1:0] S_SHL  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_data_nxt;
  logic [CW-1:0]    r_n;
  logic [CW-1:0]    w_n_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] w_out_nxt;

  logic w_accept;
  logic w_ovf;

  assign w_accept = In_valid && (r_state == S_IDLE);
  // Upper In2 bits only matter here: any count of WIDTH or more clears everything.
  assign w_ovf    = (In2 >= 32'(WIDTH));

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_n_nxt     = r_n;
    w_cnt_nxt   = r_cnt;
    w_out_nxt   = r_out;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_SHR;
          if (w_ovf) begin
            // Zero data with a zero count runs both phases in one cycle each.
            w_data_nxt = '0;
            w_n_nxt    = '0;
            w_cnt_nxt  = '0;
          end else begin
            w_data_nxt = In1;
            w_n_nxt    = In2[CW-1:0];
            w_cnt_nxt  = In2[CW-1:0];
          end
        end
      end
      S_SHR: begin
        if (r_cnt != '0) begin
          w_data_nxt = r_data >> 1;
          w_cnt_nxt  = r_cnt - 1'b1;
        end else begin
          w_cnt_nxt   = r_n;
          w_state_nxt = S_SHL;
        end
      end
      S_SHL: begin
        if (r_cnt != '0) begin
          w_data_nxt = r_data << 1;
          w_cnt_nxt  = r_cnt - 1'b1;
        end else begin
          w_out_nxt   = r_data;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (Out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_n     <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_n     <= w_n_nxt;
      r_cnt   <= w_cnt_nxt;
      r_out   <= w_out_nxt;
    end
  end

  // Handshake outputs decode the state register only, so there is no
  // combinational path from In_valid or Out_ready.
  assign In_ready  = (r_state == S_IDLE);
  assign Out_valid = (r_state == S_DONE);
  assign Busy      = (r_state != S_IDLE);
  assign Out       = r_out;

endmodule

// File: tb/tb_g_htruncated_seq.sv
module tb_g_htruncated_seq;

  logic        clk;
  logic        rst_n;
  logic [31:0] In1;
  logic [31:0] In2;
  logic        In_valid;
  logic        In_ready;
  logic [31:0] Out;
  logic        Out_valid;
  logic        Out_ready;
  logic        Busy;

  int n_checks;
  int n_pass;

  g_htruncated_seq #(
    .WIDTH(32),
    .CW   (5)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .In1      (In1),
    .In2      (In2),
    .In_valid (In_valid),
    .In_ready (In_ready),
    .Out      (Out),
    .Out_valid(Out_valid),
    .Out_ready(Out_ready),
    .Busy     (Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: truncation by arithmetic, latency from the phase-length rule.
  function automatic logic [31:0] ref_out(input logic [31:0] a, input logic [31:0] b);
    if (b >= 32) return 32'd0;
    return (a >> b) << b;
  endfunction

  function automatic int ref_lat(input logic [31:0] b);
    if (b >= 32) return 3;
    return 2 * int'(b) + 3;
  endfunction

  // Present an operand, wait for acceptance, wait for Out_valid and check
  // result and latency (accept edge counted as clock 1).
  task automatic start_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic full_chk);
    int guard;
    int lat;
    @(negedge clk);
    In1      = a;
    In2      = b;
    In_valid = 1'b1;
    guard    = 0;
    while (!In_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    #1;
    In_valid = 1'b0;
    In1      = $urandom;
    In2      = $urandom;
    lat      = 1;
    while (!Out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (full_chk || lat != ref_lat(b)) chk({tag, "_lat"}, 32'(lat), 32'(ref_lat(b)));
    chk({tag, "_out"}, Out, ref_out(a, b));
  endtask

  // Hold Out_ready low for 'hold' cycles, then complete the handshake.
  task automatic finish_op(input string tag, input logic [31:0] exp, input int hold,
                           input logic full_chk);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      if (full_chk) begin
        chk({tag, "_hold_valid"}, 32'(Out_valid), 32'd1);
        chk({tag, "_hold_out"}, Out, exp);
        chk({tag, "_hold_inrdy"}, 32'(In_ready), 32'd0);
      end
    end
    @(negedge clk);
    Out_ready = 1'b1;
    @(posedge clk);
    #1;
    Out_ready = 1'b0;
    chk({tag, "_post_valid"}, 32'(Out_valid), 32'd0);
    chk({tag, "_post_out"}, Out, exp);
    if (full_chk) chk({tag, "_post_inrdy"}, 32'(In_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    In1       = '0;
    In2       = '0;
    In_valid  = 1'b0;
    Out_ready = 1'b0;

    #12;
    chk("rst_out", Out, 32'd0);
    chk("rst_valid", 32'(Out_valid), 32'd0);
    chk("rst_inrdy", 32'(In_ready), 32'd1);
    chk("rst_busy", 32'(Busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    start_op("c1", 32'hDEADBEEF, 32'd8, 1'b1);
    chk("c1_busy", 32'(Busy), 32'd1);
    finish_op("c1", 32'hDEADBE00, 0, 1'b1);
    start_op("c2", 32'h12345678, 32'd0, 1'b1);
    finish_op("c2", 32'h12345678, 1, 1'b1);
    start_op("c3a", 32'hFFFFFFFF, 32'd31, 1'b1);
    chk("c3a_exact", Out, 32'h80000000);
    finish_op("c3a", 32'h80000000, 0, 1'b1);
    start_op("c3b", 32'hFFFFFFFF, 32'd32, 1'b1);
    finish_op("c3b", 32'h0, 0, 1'b1);
    start_op("c3c", 32'hFFFFFFFF, 32'h80000004, 1'b1);
    finish_op("c3c", 32'h0, 0, 1'b1);

    // Backpressure with a second operand held on the input
    start_op("c4", 32'hA5A5A5A5, 32'd4, 1'b1);
    chk("c4_exact", Out, 32'hA5A5A5A0);
    @(negedge clk);
    In1      = 32'h0F0F0F0F;
    In2      = 32'd4;
    In_valid = 1'b1;
    finish_op("c4", 32'hA5A5A5A0, 10, 1'b1);
    start_op("c4b", 32'h0F0F0F0F, 32'd4, 1'b1);
    finish_op("c4b", 32'h0F0F0F00, 0, 1'b1);

    // Reset in the SHL phase of case 1
    @(negedge clk);
    In1      = 32'hDEADBEEF;
    In2      = 32'd8;
    In_valid = 1'b1;
    @(posedge clk);
    #1;
    In_valid = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("c5_out", Out, 32'd0);
    chk("c5_valid", 32'(Out_valid), 32'd0);
    chk("c5_inrdy", 32'(In_ready), 32'd1);
    chk("c5_busy", 32'(Busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_op("c5b", 32'hFFFF0000, 32'd16, 1'b1);
    finish_op("c5b", 32'hFFFF0000, 0, 1'b1);

    // Random regression
    for (int i = 0; i < 800; i++) begin
      a = $urandom;
      b = 32'($urandom_range(40, 0));
      start_op("rnd", a, b, 1'b0);
      finish_op("rnd", ref_out(a, b), int'($urandom_range(3, 0)), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
